// File: rtl/ball_pkg.sv
// Shared constants and types for the ball sprite motion controller:
// HID keycodes, default screen bounds and the run/pause state encoding.
package ball_pkg;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int SCREEN_X_MIN = 0;
    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MIN = 0;
    localparam int SCREEN_Y_MAX = 479;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } run_state_t;

endpackage

// File: rtl/vs_tick.sv
// Brings the asynchronous VGA vertical sync into the clk_clk domain and emits
// a registered one-cycle pulse on each of its rising edges.
module vs_tick (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic async_in,
    output logic tick
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic tick_q;
    logic tick_d;

    // Registered pulse: rising edge sampled at edge N shows as tick in cycle N+2.
    always_comb begin
        tick_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball motion: keyboard-steered direction, edge bounce, and a
// Space-toggled pause that freezes motion while still counting frames.
module ball_motion
    import ball_pkg::*;
#(
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 240,
    parameter int X_MIN    = SCREEN_X_MIN,
    parameter int X_MAX    = SCREEN_X_MAX,
    parameter int Y_MIN    = SCREEN_Y_MIN,
    parameter int Y_MAX    = SCREEN_Y_MAX,
    parameter int STEP     = 1,
    parameter int SIZE     = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        frame_vs,
    input  logic [7:0]  keycode,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [9:0]  ball_size,
    output logic        paused,
    output logic [15:0] frame_count
);

    localparam logic signed [9:0] STEP_POS = 10'(STEP);
    localparam logic signed [9:0] STEP_NEG = -STEP_POS;

    logic              tick;
    logic [7:0]        kc_q;
    logic              press;
    run_state_t        state_q;
    run_state_t        state_d;
    logic signed [9:0] mx_q;
    logic signed [9:0] my_q;
    logic signed [9:0] mx_d;
    logic signed [9:0] my_d;
    logic [9:0]        ball_x_q;
    logic [9:0]        ball_y_q;
    logic [9:0]        ball_x_d;
    logic [9:0]        ball_y_d;
    logic [15:0]       frame_count_q;

    vs_tick u_vs_tick (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .async_in    (frame_vs),
        .tick        (tick)
    );

    assign press = (keycode == KEY_SPACE) && (kc_q != KEY_SPACE);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (press) begin
            state_d = (state_q == RUN) ? PAUSED : RUN;
        end
    end

    always_comb begin
        paused = (state_q == PAUSED);
    end

    // Key decode first, then bounce on the current position overrides per axis.
    always_comb begin
        mx_d = mx_q;
        my_d = my_q;
        case (keycode)
            KEY_W: begin mx_d = '0;       my_d = STEP_NEG; end
            KEY_S: begin mx_d = '0;       my_d = STEP_POS; end
            KEY_A: begin mx_d = STEP_NEG; my_d = '0;       end
            KEY_D: begin mx_d = STEP_POS; my_d = '0;       end
            default: ;
        endcase
        if ((int'(ball_x_q) + SIZE >= X_MAX) && (mx_d > 0)) begin
            mx_d = STEP_NEG;
        end else if ((int'(ball_x_q) < X_MIN + SIZE) && (mx_d < 0)) begin
            mx_d = STEP_POS;
        end
        if ((int'(ball_y_q) + SIZE >= Y_MAX) && (my_d > 0)) begin
            my_d = STEP_NEG;
        end else if ((int'(ball_y_q) < Y_MIN + SIZE) && (my_d < 0)) begin
            my_d = STEP_POS;
        end
        ball_x_d = ball_x_q + $unsigned(mx_d);
        ball_y_d = ball_y_q + $unsigned(my_d);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            kc_q          <= 8'h00;
            mx_q          <= '0;
            my_q          <= '0;
            ball_x_q      <= 10'(X_CENTER);
            ball_y_q      <= 10'(Y_CENTER);
            frame_count_q <= '0;
        end else begin
            kc_q <= keycode;
            if (tick) begin
                frame_count_q <= frame_count_q + 16'd1;
                if (state_q == RUN) begin
                    mx_q     <= mx_d;
                    my_q     <= my_d;
                    ball_x_q <= ball_x_d;
                    ball_y_q <= ball_y_d;
                end
            end
        end
    end

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign ball_size   = 10'(SIZE);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: a vector table of key/tick phases plus
// hand sequences for pause, tick latency and reset during motion.
module tb_ball_motion;

    logic        clk_clk;
    logic        reset_reset;
    logic        frame_vs;
    logic [7:0]  keycode;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [9:0]  ball_size;
    logic        paused;
    logic [15:0] frame_count;

    int errors = 0;
    int checks = 0;

    ball_motion dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .frame_vs    (frame_vs),
        .keycode     (keycode),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .ball_size   (ball_size),
        .paused      (paused),
        .frame_count (frame_count)
    );

    // Clock and reset
    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] key;
        int         ticks;
        int         exp_x;
        int         exp_y;
        int         exp_fc;
        int         exp_paused;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int ex, input int ey,
                               input int efc, input int ep);
        check({tag, " ball_x"}, int'(ball_x), ex);
        check({tag, " ball_y"}, int'(ball_y), ey);
        check({tag, " frame_count"}, int'(frame_count), efc);
        check({tag, " paused"}, int'(paused), ep);
    endtask

    // One full vsync pulse; all effects of the tick have landed on return.
    task automatic do_tick();
        @(negedge clk_clk);
        frame_vs = 1'b1;
        repeat (4) @(negedge clk_clk);
        frame_vs = 1'b0;
        repeat (2) @(negedge clk_clk);
    endtask

    initial begin
        vecs[0] = '{8'h00, 3,   320, 240, 3,   0};
        vecs[1] = '{8'h07, 10,  330, 240, 13,  0};
        vecs[2] = '{8'h00, 5,   335, 240, 18,  0};
        vecs[3] = '{8'h16, 235, 335, 475, 253, 0};
        vecs[4] = '{8'h00, 1,   335, 474, 254, 0};
        vecs[5] = '{8'h00, 1,   335, 473, 255, 0};

        reset_reset = 1'b1;
        frame_vs    = 1'b0;
        keycode     = 8'h00;
        repeat (3) @(negedge clk_clk);
        check_state("reset", 320, 240, 0, 0);
        check("reset ball_size", int'(ball_size), 4);
        reset_reset = 1'b0;
        @(negedge clk_clk);

        for (int i = 0; i < 6; i++) begin
            keycode = vecs[i].key;
            repeat (vecs[i].ticks) do_tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_y,
                        vecs[i].exp_fc, vecs[i].exp_paused);
        end

        // Pause: held Space toggles once, ticks still counted, motion frozen.
        @(negedge clk_clk);
        keycode = 8'h2C;
        @(negedge clk_clk);
        check("pause latency", int'(paused), 1);
        repeat (20) @(negedge clk_clk);
        repeat (4) do_tick();
        check_state("paused hold", 335, 473, 259, 1);
        keycode = 8'h00;
        repeat (3) @(negedge clk_clk);
        check("pause after release", int'(paused), 1);
        keycode = 8'h2C;
        @(negedge clk_clk);
        check("unpause", int'(paused), 0);
        repeat (3) @(negedge clk_clk);
        check("unpause held", int'(paused), 0);
        keycode = 8'h00;
        do_tick();
        check_state("resume motion", 335, 472, 260, 0);

        // Latency: frame_vs sampled at edge N moves the ball at edge N+3.
        keycode = 8'h07;
        @(negedge clk_clk);
        frame_vs = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk_clk);
            check($sformatf("latency edge N+%0d ball_x", e), int'(ball_x), 335);
        end
        @(negedge clk_clk);
        check("latency edge N+3 ball_x", int'(ball_x), 336);
        check("latency edge N+3 frame_count", int'(frame_count), 261);
        frame_vs = 1'b0;
        repeat (3) @(negedge clk_clk);

        repeat (14) do_tick();
        check_state("key D to 350", 350, 472, 275, 0);

        // Reset during motion returns to centre with zero motion.
        reset_reset = 1'b1;
        @(negedge clk_clk);
        check_state("reset mid-motion", 320, 240, 0, 0);
        reset_reset = 1'b0;
        keycode = 8'h00;
        do_tick();
        check_state("after reset tick", 320, 240, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
